// File: rtl/present_serial_round_ctrl.sv
// present_serial_round_ctrl: nibble-serial PRESENT round sequencer sharing one external S-box+key-add datapath.
// Optional DOUBLE_EXEC_EN: each nibble is evaluated twice and compared, with a sticky fault flag and output suppression.
module present_serial_round_ctrl #(
  parameter int ROUNDS = 2,
  parameter int RCW = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_start,
  input  logic [63:0]    io_plain,
  input  logic [63:0]    io_roundKey,
  output logic [RCW-1:0] io_round,
  output logic           io_busy,
  output logic           io_done,
  output logic [63:0]    io_out,
  output logic           io_fault,
  output logic [3:0]     sbox_state,
  output logic [3:0]     sbox_key,
  input  logic [3:0]     sbox_out
);
  typedef enum logic [1:0] {IDLE, SBOX, PERM, DONE} st_t;
  st_t            st_q;
  logic [63:0]    state_q, out_q, perm_d, upd_d;
  logic [3:0]     idx_q;
  logic [RCW-1:0] round_q;
`ifdef DOUBLE_EXEC_EN
  logic           phase_q, fault_q;
  logic [3:0]     tmp_q;
  assign io_fault = fault_q;
`else
  assign io_fault = 1'b0;
`endif
  assign io_round   = round_q;
  assign io_busy    = st_q != IDLE;
  assign io_done    = st_q == DONE;
  assign io_out     = out_q;
  assign sbox_state = st_q == SBOX ? state_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign sbox_key   = st_q == SBOX ? io_roundKey[{idx_q, 2'b00} +: 4] : 4'h0;
  // pLayer: bit i -> 16*i mod 63, bit 63 fixed
  always_comb begin
    perm_d = state_q;
    for (int i = 0; i < 63; i++) perm_d[6'((16 * i) % 63)] = state_q[i];
  end
  always_comb begin
    upd_d = state_q;
    upd_d[{idx_q, 2'b00} +: 4] = sbox_out;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= IDLE;
      state_q <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      round_q <= '0;
`ifdef DOUBLE_EXEC_EN
      phase_q <= 1'b0;
      fault_q <= 1'b0;
      tmp_q   <= '0;
`endif
    end else begin
      case (st_q)
        IDLE: if (io_start) begin
          st_q    <= SBOX;
          state_q <= io_plain;
          idx_q   <= '0;
          round_q <= '0;
`ifdef DOUBLE_EXEC_EN
          phase_q <= 1'b0;
          fault_q <= 1'b0;
`endif
        end
        SBOX: begin
`ifdef DOUBLE_EXEC_EN
          phase_q <= ~phase_q;
          if (!phase_q) tmp_q <= sbox_out;
          else begin
            if (sbox_out == tmp_q) state_q <= upd_d;
            else fault_q <= 1'b1;
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'hf) st_q <= PERM;
          end
`else
          state_q <= upd_d;
          idx_q   <= idx_q + 4'd1;
          if (idx_q == 4'hf) st_q <= PERM;
`endif
        end
        PERM: begin
          state_q <= perm_d;
          if (round_q == RCW'(ROUNDS - 1)) begin
            st_q  <= DONE;
            out_q <= io_fault ? '0 : perm_d;
          end else begin
            round_q <= round_q + RCW'(1);
            st_q    <= SBOX;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_present_serial_round_ctrl.sv
// tb_present_serial_round_ctrl: directed checks of the serial PRESENT sequencer with a bench-side S-box+key datapath.
module tb_present_serial_round_ctrl;
`ifdef DOUBLE_EXEC_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int PR = 16 * PH + 1;
  localparam logic [63:0] K0 = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] K1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] R_ZERO = 64'hFFFF_FFFF_0000_0000;
  logic        clock = 1'b0, reset = 1'b1, start1 = 1'b0, start2 = 1'b0, flip = 1'b0;
  logic [63:0] plain1 = '0, plain2 = 64'h0123_4567_89AB_CDEF, key1 = '0, key2;
  logic [4:0]  rnd1, rnd2;
  logic        busy1, busy2, done1, done2, flt1, flt2;
  logic [63:0] out1, out2;
  logic [3:0]  ss1, sk1, so1, ss2, sk2, so2;
  logic [63:0] mi [2];
  logic [63:0] gold;
  int          total = 0, passed = 0;
  always #5 clock = ~clock;
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [63:0] rnd(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t, o;
    for (int j = 0; j < 16; j++) t[4*j +: 4] = sb(s[4*j +: 4]) ^ k[4*j +: 4];
    for (int i = 0; i < 64; i++) o[16*(i%4) + i/4] = t[i];
    return o;
  endfunction
  assign so1  = sb(ss1) ^ sk1 ^ {3'b000, flip};
  assign so2  = sb(ss2) ^ sk2;
  assign key2 = rnd2 == 5'd0 ? K0 : K1;
  present_serial_round_ctrl #(.ROUNDS(1)) u1 (
    .clock(clock), .reset(reset), .io_start(start1), .io_plain(plain1), .io_roundKey(key1),
    .io_round(rnd1), .io_busy(busy1), .io_done(done1), .io_out(out1), .io_fault(flt1),
    .sbox_state(ss1), .sbox_key(sk1), .sbox_out(so1));
  present_serial_round_ctrl #(.ROUNDS(2)) u2 (
    .clock(clock), .reset(reset), .io_start(start2), .io_plain(plain2), .io_roundKey(key2),
    .io_round(rnd2), .io_busy(busy2), .io_done(done2), .io_out(out2), .io_fault(flt2),
    .sbox_state(ss2), .sbox_key(sk2), .sbox_out(so2));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic go1();
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
  endtask
  task automatic wait1(output int n);
    n = 0;
    while (!done1 && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask
  initial begin
    int n, r, p, idx;
    mi[0] = plain2;
    mi[1] = rnd(plain2, K0);
    gold  = rnd(mi[1], K1);
    repeat (2) @(negedge clock);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_out", out1, 0);
    check("rst_fault", flt1, 0);
    check("rst_round", rnd2, 0);
    check("rst_sbox", {ss1, sk1, ss2, sk2}, 0);
    reset = 1'b0;
    go1();
    wait1(n);
    check("t1_lat", n, PR);
    check("t1_busy_done", busy1, 1);
    check("t1_out", out1, R_ZERO);
    @(negedge clock);
    check("t1_busy_fall", busy1, 0);
    check("t1_done_pulse", done1, 0);
    key1 = '1;
    go1();
    wait1(n);
    check("t2_lat", n, PR);
    check("t2_out", out1, 64'h0000_0000_FFFF_FFFF);
    key1 = '0;
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    for (n = 0; n <= 2 * PR; n++) begin
      r = n / PR;
      p = n % PR;
      check("t3_done", done2, n == 2 * PR);
      if (n < 2 * PR) begin
        check("t3_round", rnd2, r);
        if (p < 16 * PH) begin
          idx = p / PH;
          check("t3_sbox_state", ss2, mi[r][4*idx +: 4]);
          check("t3_sbox_key", sk2, (r == 0 ? K0[4*idx +: 4] : K1[4*idx +: 4]));
        end else check("t3_perm_idle_sbox", {ss2, sk2}, 0);
        @(negedge clock);
      end
    end
    check("t3_out", out2, gold);
    check("t3_fault", flt2, 0);
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
    n = 0;
    while (!done1 && n < 200) begin
      start1 = n == 5;
      @(negedge clock);
      n++;
    end
    start1 = 1'b0;
    check("t4_lat", n, PR);
    check("t4_out", out1, R_ZERO);
    start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
    check("t4_done_start_ignored", busy1, 0);
    @(negedge clock);
    check("t4_still_idle", busy1, 0);
    go1();
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_busy", busy1, 0);
    check("t5_out", out1, 0);
    reset = 1'b0;
    go1();
    wait1(n);
    check("t5_lat", n, PR);
    check("t5_out_fresh", out1, R_ZERO);
`ifdef DOUBLE_EXEC_EN
    go1();
    repeat (15) @(negedge clock);
    check("t6_fault_pre", flt1, 0);
    flip = 1'b1;
    @(negedge clock) flip = 1'b0;
    check("t6_fault_set", flt1, 1);
    n = 16;
    while (!done1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t6_lat", n, PR);
    check("t6_out_suppressed", out1, 0);
    check("t6_fault_sticky", flt1, 1);
    go1();
    check("t6_fault_clear", flt1, 0);
    wait1(n);
    check("t6_clean_out", out1, R_ZERO);
    check("t6_clean_fault", flt1, 0);
`else
    check("fault_tied", flt1, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
